// File: rtl/adc_avg_sequencer.sv
// rtl/adc_avg_sequencer.sv - multi-pass averaging trigger sequencer for one ADC capture channel
// Optional macro ADC_SEQ_EXT_TRIG_EN: every pass waits for an ext_trig rising edge.
module adc_avg_sequencer #(
   parameter int CNT_W = 32,
   parameter int AVG_W = 16
) (
   input  logic             rf_clk,
   input  logic             rf_reset,
   input  logic             start,
   input  logic             abort,
   input  logic [AVG_W-1:0] num_avg,
   input  logic [CNT_W-1:0] capture_len,
   input  logic [CNT_W-1:0] holdoff,
   input  logic             ext_trig,
   input  logic             readout_ack,
   output logic             trigger_out,
   output logic [4:0]       shift_out,
   output logic             readout_req,
   output logic             busy,
   output logic [AVG_W-1:0] pass_count,
   output logic             cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_HOLD,
      S_WAIT_EXT,
      S_READOUT
   } state_t;

   state_t           state;
   logic [AVG_W-1:0] num_q;
   logic [CNT_W-1:0] len_q;
   logic [CNT_W-1:0] hold_q;
   logic [CNT_W-1:0] cnt;

   // ceil(log2(n)) is the bit length of n-1, saturated to the 5-bit shift field.
   function automatic logic [4:0] calc_shift(input logic [AVG_W-1:0] n);
      logic [AVG_W-1:0] m;
      int               r;
      m = n - AVG_W'(1);
      r = 0;
      for (int i = 0; i < AVG_W; i++) begin
         if (m[i]) r = i + 1;
      end
      return (r > 31) ? 5'd31 : r[4:0];
   endfunction

`ifdef ADC_SEQ_EXT_TRIG_EN
   logic ext_trig_q;
   logic ext_rise;

   always_ff @(posedge rf_clk) begin
      if (rf_reset) ext_trig_q <= 1'b0;
      else          ext_trig_q <= ext_trig;
   end

   assign ext_rise = ext_trig & ~ext_trig_q;
`else
   logic unused_ext_trig;
   assign unused_ext_trig = ext_trig;
`endif

   always_ff @(posedge rf_clk) begin
      if (rf_reset) begin
         state       <= S_IDLE;
         trigger_out <= 1'b0;
         shift_out   <= 5'd0;
         readout_req <= 1'b0;
         busy        <= 1'b0;
         pass_count  <= '0;
         cfg_err     <= 1'b0;
         num_q       <= '0;
         len_q       <= '0;
         hold_q      <= '0;
         cnt         <= '0;
      end else begin
         cfg_err <= 1'b0;
         if (abort) begin
            state       <= S_IDLE;
            trigger_out <= 1'b0;
            readout_req <= 1'b0;
            shift_out   <= 5'd0;
            busy        <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     if (num_avg == '0 || capture_len == '0) begin
                        cfg_err <= 1'b1;
                     end else begin
                        num_q      <= num_avg;
                        len_q      <= capture_len;
                        // A zero holdoff still leaves one low cycle between windows.
                        hold_q     <= (holdoff == '0) ? CNT_W'(1) : holdoff;
                        pass_count <= '0;
                        shift_out  <= calc_shift(num_avg);
                        busy       <= 1'b1;
                        cnt        <= CNT_W'(1);
`ifdef ADC_SEQ_EXT_TRIG_EN
                        state      <= S_WAIT_EXT;
`else
                        state       <= S_TRIG;
                        trigger_out <= 1'b1;
`endif
                     end
                  end
               end
               S_TRIG: begin
                  if (cnt == len_q) begin
                     trigger_out <= 1'b0;
                     cnt         <= CNT_W'(1);
                     pass_count  <= pass_count + AVG_W'(1);
                     if (pass_count + AVG_W'(1) == num_q) begin
                        readout_req <= 1'b1;
                        state       <= S_READOUT;
                     end else begin
                        state <= S_HOLD;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               S_HOLD: begin
                  if (cnt == hold_q) begin
`ifdef ADC_SEQ_EXT_TRIG_EN
                     state       <= S_WAIT_EXT;
`else
                     state       <= S_TRIG;
                     trigger_out <= 1'b1;
                     cnt         <= CNT_W'(1);
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
`ifdef ADC_SEQ_EXT_TRIG_EN
               S_WAIT_EXT: begin
                  if (ext_rise) begin
                     state       <= S_TRIG;
                     trigger_out <= 1'b1;
                     cnt         <= CNT_W'(1);
                  end
               end
`endif
               S_READOUT: begin
                  if (readout_ack) begin
                     readout_req <= 1'b0;
                     shift_out   <= 5'd0;
                     busy        <= 1'b0;
                     state       <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_avg_sequencer.sv
// tb/tb_adc_avg_sequencer.sv - randomized self-checking bench for adc_avg_sequencer
module tb_adc_avg_sequencer;
   localparam int CNT_W = 32;
   localparam int AVG_W = 16;

   logic             rf_clk = 1'b0;
   logic             rf_reset;
   logic             start;
   logic             abort;
   logic [AVG_W-1:0] num_avg;
   logic [CNT_W-1:0] capture_len;
   logic [CNT_W-1:0] holdoff;
   logic             ext_trig;
   logic             readout_ack;
   logic             trigger_out;
   logic [4:0]       shift_out;
   logic             readout_req;
   logic             busy;
   logic [AVG_W-1:0] pass_count;
   logic             cfg_err;

   int errors = 0;
   int checks = 0;
   int last_pc = 0;

   always #5 rf_clk = ~rf_clk;

   adc_avg_sequencer #(.CNT_W(CNT_W), .AVG_W(AVG_W)) dut (
      .rf_clk      (rf_clk),
      .rf_reset    (rf_reset),
      .start       (start),
      .abort       (abort),
      .num_avg     (num_avg),
      .capture_len (capture_len),
      .holdoff     (holdoff),
      .ext_trig    (ext_trig),
      .readout_ack (readout_ack),
      .trigger_out (trigger_out),
      .shift_out   (shift_out),
      .readout_req (readout_req),
      .busy        (busy),
      .pass_count  (pass_count),
      .cfg_err     (cfg_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference timing: window k covers cycles [k*p, k*p+cl) after the accepting edge.
   function automatic int passes_done(input int na, input int cl, input int p, input int n);
      int c = 0;
      for (int k = 0; k < na; k++) if (n >= k * p + cl) c++;
      return c;
   endfunction

   function automatic int trig_at(input int na, input int cl, input int p, input int n);
      for (int k = 0; k < na; k++) if (n >= k * p && n < k * p + cl) return 1;
      return 0;
   endfunction

   function automatic int ceil_log2(input int na);
      int s = 0;
      while ((1 << s) < na) s++;
      return s;
   endfunction

   task automatic check_all(input string ph, input int trg, input int req, input int bsy,
                            input int sh, input int pc);
      check({ph, "_trigger"}, 32'(trigger_out), trg);
      check({ph, "_req"},     32'(readout_req), req);
      check({ph, "_busy"},    32'(busy), bsy);
      check({ph, "_shift"},   32'(shift_out), sh);
      check({ph, "_pass"},    32'(pass_count), pc);
      check({ph, "_cfg_err"}, 32'(cfg_err), 0);
   endtask

   task automatic idle_inputs();
      start       = 1'b0;
      abort       = 1'b0;
      rf_reset    = 1'b0;
      readout_ack = 1'b0;
   endtask

   // kind: 0 = normal with ack, 1 = abort, 2 = reset; stop_at is the cycle the abort/reset is driven.
   task automatic do_run(input int na, input int cl, input int ho, input int kind,
                         input int stop_at, input int ack_wait);
      int p, rise, ackn, endn, sh;
      p    = cl + ((ho == 0) ? 1 : ho);
      rise = (na - 1) * p + cl;
      ackn = rise + ack_wait;
      endn = (kind == 0) ? ackn + 2 : stop_at + 2;
      sh   = ceil_log2(na);
      @(negedge rf_clk);
      num_avg     = AVG_W'(na);
      capture_len = CNT_W'(cl);
      holdoff     = CNT_W'(ho);
      start       = 1'b1;
      @(negedge rf_clk);
      for (int n = 0; n <= endn; n++) begin
         if (kind != 0 && n > stop_at)
            check_all("stopped", 0, 0, 0, 0, (kind == 1) ? passes_done(na, cl, p, stop_at) : 0);
         else if (kind == 0 && n > ackn)
            check_all("acked", 0, 0, 0, 0, na);
         else
            check_all("run", trig_at(na, cl, p, n), (n >= rise) ? 1 : 0, 1, sh,
                      passes_done(na, cl, p, n));
         start       = (n < endn - 2) && ($urandom_range(0, 3) == 0);
         abort       = (kind == 1 && n == stop_at);
         if (kind == 1 && n == stop_at) start = 1'b1;
         rf_reset    = (kind == 2 && n == stop_at);
         readout_ack = (kind == 0 && n == ackn) || (n < rise && $urandom_range(0, 3) == 0);
         ext_trig    = 1'($urandom_range(0, 1));
         num_avg     = AVG_W'($urandom);
         capture_len = CNT_W'($urandom_range(0, 20));
         holdoff     = CNT_W'($urandom);
         @(negedge rf_clk);
      end
      idle_inputs();
      last_pc = (kind == 0) ? na : (kind == 1) ? passes_done(na, cl, p, stop_at) : 0;
   endtask

   task automatic cfg_reject(input int na, input int cl);
      @(negedge rf_clk);
      num_avg     = AVG_W'(na);
      capture_len = CNT_W'(cl);
      holdoff     = CNT_W'($urandom_range(0, 5));
      start       = 1'b1;
      @(negedge rf_clk);
      start = 1'b0;
      check("cfg_err_pulse", 32'(cfg_err), 1);
      check("cfg_err_busy", 32'(busy), 0);
      check("cfg_err_trigger", 32'(trigger_out), 0);
      check("cfg_err_pass_held", 32'(pass_count), last_pc);
      @(negedge rf_clk);
      check("cfg_err_clear", 32'(cfg_err), 0);
      check("cfg_err_busy2", 32'(busy), 0);
   endtask

   initial begin
      idle_inputs();
      rf_reset    = 1'b1;
      ext_trig    = 1'b0;
      num_avg     = '0;
      capture_len = '0;
      holdoff     = '0;
      repeat (3) @(negedge rf_clk);
      check_all("reset", 0, 0, 0, 0, 0);
      rf_reset = 1'b0;

      do_run(4, 8, 3, 0, 0, 2);
      do_run(1, 1, 0, 0, 0, 0);
      cfg_reject(0, 5);
      cfg_reject(3, 0);
      do_run(5, 3, 2, 0, 0, 1);
      do_run(3, 8, 4, 1, 14, 0);

      @(negedge rf_clk);
      num_avg     = AVG_W'(2);
      capture_len = CNT_W'(4);
      holdoff     = CNT_W'(1);
      start       = 1'b1;
      abort       = 1'b1;
      @(negedge rf_clk);
      idle_inputs();
      check("start_abort_busy", 32'(busy), 0);
      check("start_abort_trigger", 32'(trigger_out), 0);
      check("start_abort_cfg_err", 32'(cfg_err), 0);
      check("start_abort_pass", 32'(pass_count), last_pc);

      do_run(2, 6, 0, 0, 0, 3);
      do_run(2, 6, 0, 2, 3, 0);

      for (int r = 0; r < 30; r++) begin
         int na, cl, ho, kind, rise;
         na   = $urandom_range(1, 6);
         cl   = $urandom_range(1, 10);
         ho   = $urandom_range(0, 5);
         kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         rise = (na - 1) * (cl + ((ho == 0) ? 1 : ho)) + cl;
         do_run(na, cl, ho, kind, $urandom_range(0, rise - 1), $urandom_range(0, 4));
         if ($urandom_range(0, 4) == 0)
            cfg_reject(($urandom_range(0, 1) == 0) ? 0 : 3, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
